// File: rtl/alu_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sweep_checker
//  Description : Exhaustive built-in checker for a small ALU. On a start
//                request it walks every {op, in_c, in_x, in_y} combination
//                and compares the ALU outputs with a built-in golden model.
//                It counts mismatching vectors and captures the first one.
//
//  Ports
//    clk        : single clock, rising edge
//    rst        : asynchronous active-high reset
//    start      : one-cycle sweep request (ignored while busy)
//    op         : ALU operation select to the ALU under test
//    in_c       : ALU carry-in to the ALU under test
//    in_x/in_y  : ALU operands to the ALU under test
//    out_s      : ALU result from the ALU under test
//    out_c      : ALU carry flag from the ALU under test
//    zero       : ALU zero flag from the ALU under test
//    overflow   : ALU signed-overflow flag from the ALU under test
//    busy       : sweep in progress
//    done       : sweep finished; held until next start or reset
//    pass       : valid with done; 1 when no vector mismatched
//    err_count  : number of mismatching vectors, saturating
//    first_err  : {op, in_c, in_x, in_y} of the first mismatching vector
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sweep_checker #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [2:0]              op,
    output logic                    in_c,
    output logic [WIDTH-1:0]        in_x,
    output logic [WIDTH-1:0]        in_y,
    input  logic [WIDTH-1:0]        out_s,
    input  logic                    out_c,
    input  logic                    zero,
    input  logic                    overflow,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_count,
    output logic [3+1+2*WIDTH-1:0]  first_err
);

    // Vector index width: op(3) + in_c(1) + in_x + in_y.
    localparam int c_VEC_W = 3 + 1 + 2 * WIDTH;
    localparam int c_MSB   = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [c_VEC_W-1:0]   r_idx;
    logic [15:0]          r_err_count;
    logic [c_VEC_W-1:0]   r_first_err;
    logic                 r_done;
    logic                 r_pass;

    logic                 w_start_ok;
    logic                 w_last;
    logic                 w_mismatch;
    logic [15:0]          w_err_inc;

    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [WIDTH-1:0]     w_exp_s;
    logic                 w_exp_c;
    logic                 w_exp_z;
    logic                 w_exp_v;

    // ------------------------------------------------------------------
    // Stimulus comes straight from the index register, so it is glitch
    // free and stays stable across DRIVE and SAMPLE. in_y is the least
    // significant field so it sweeps fastest, op the slowest.
    // ------------------------------------------------------------------
    assign in_y      = r_idx[0 +: WIDTH];
    assign in_x      = r_idx[WIDTH +: WIDTH];
    assign in_c      = r_idx[2*WIDTH];
    assign op        = r_idx[2*WIDTH+1 +: 3];

    assign busy      = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign first_err = r_first_err;

    // Start is honoured only when no sweep is running.
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_FIN));
    assign w_last     = &r_idx;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_state_next = w_last ? S_FIN : S_DRIVE;
            end
            S_FIN: begin
                if (start) begin
                    w_state_next = S_DRIVE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Golden ALU model, evaluated on the vector currently presented.
    // The extra top bit of the subtract result is the borrow, which is
    // exactly "unsigned x < y".
    // ------------------------------------------------------------------
    assign w_add = {1'b0, in_x} + {1'b0, in_y} + {{WIDTH{1'b0}}, in_c};
    assign w_sub = {1'b0, in_x} - {1'b0, in_y};

    always_comb begin
        w_exp_s = '0;
        w_exp_c = 1'b0;
        w_exp_v = 1'b0;
        case (op)
            3'b000: begin
                w_exp_s = w_add[WIDTH-1:0];
                w_exp_c = w_add[WIDTH];
                // Same-signed operands producing a differently signed result.
                w_exp_v = (in_x[c_MSB] == in_y[c_MSB]) &&
                          (w_add[c_MSB] != in_x[c_MSB]);
            end
            3'b001: begin
                w_exp_s = w_sub[WIDTH-1:0];
                w_exp_c = w_sub[WIDTH];
                // Opposite-signed operands where the result sign leaves x's.
                w_exp_v = (in_x[c_MSB] != in_y[c_MSB]) &&
                          (w_sub[c_MSB] != in_x[c_MSB]);
            end
            3'b010: w_exp_s = ~in_x;
            3'b011: w_exp_s = in_x & in_y;
            3'b100: w_exp_s = in_x | in_y;
            3'b101: w_exp_s = in_x ^ in_y;
            3'b110: w_exp_s[0] = ($signed(in_x) < $signed(in_y));
            3'b111: w_exp_s[0] = (in_x == in_y);
            default: w_exp_s = '0;
        endcase
    end

    assign w_exp_z = (w_exp_s == '0);

    // Any field differing makes the whole vector one error.
    assign w_mismatch = (out_s != w_exp_s) || (out_c != w_exp_c) ||
                        (zero != w_exp_z) || (overflow != w_exp_v);

    assign w_err_inc  = (r_err_count == 16'hFFFF) ? r_err_count
                                                   : r_err_count + 16'd1;

    // ------------------------------------------------------------------
    // Sweep datapath: index, error accounting and result flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else if (w_start_ok) begin
            r_idx       <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else if (r_state == S_SAMPLE) begin
            if (w_mismatch) begin
                r_err_count <= w_err_inc;
                // The count only ever grows, so zero means nothing seen yet.
                if (r_err_count == 16'd0) begin
                    r_first_err <= r_idx;
                end
            end
            if (w_last) begin
                // Final vector: the index is left in place rather than wrapped.
                r_done <= 1'b1;
                r_pass <= !w_mismatch && (r_err_count == 16'd0);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sweep_checker
//  Description : Self-checking bench for alu_sweep_checker. A behavioural
//                ALU with selectable faults answers the checker; expected
//                sweep results are queued when a sweep is started and
//                compared when done rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sweep_checker;

    localparam int W  = 4;
    localparam int NV = 4 + 2 * W;
    localparam int NVEC = 1 << NV;
    localparam int SWEEP_LAT = 2 * NVEC + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      op;
    logic            in_c;
    logic [W-1:0]    in_x;
    logic [W-1:0]    in_y;
    logic [W-1:0]    out_s;
    logic            out_c;
    logic            zero;
    logic            overflow;
    logic            busy;
    logic            done;
    logic            pass;
    logic [15:0]     err_count;
    logic [NV-1:0]   first_err;

    int fault_mode;   // 0 good ALU, 1 out_s stuck at 0, 2 add overflow inverted
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic pass;
        int   errs;
        int   first;
        int   lat;
    } exp_t;

    exp_t sb[$];

    alu_sweep_checker #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .in_c      (in_c),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_s     (out_s),
        .out_c     (out_c),
        .zero      (zero),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .first_err (first_err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU written with integer arithmetic; overflow is judged
    // by whether the true signed result fits in W bits.
    function automatic logic [W+2:0] alu_ref(input logic [2:0] f_op, input logic f_c,
                                             input logic [W-1:0] f_x, input logic [W-1:0] f_y,
                                             input int mode);
        int ux, uy, sx, sy, r, sr;
        logic [W-1:0] s;
        logic c, v;
        ux = int'(f_x);
        uy = int'(f_y);
        sx = $signed(f_x);
        sy = $signed(f_y);
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (f_op)
            3'd0: begin
                r  = ux + uy + int'(f_c);
                s  = r[W-1:0];
                c  = (r >= (1 << W));
                sr = sx + sy + int'(f_c);
                v  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
            end
            3'd1: begin
                r  = ux - uy;
                s  = r[W-1:0];
                c  = (ux < uy);
                sr = sx - sy;
                v  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
            end
            3'd2: s = ~f_x;
            3'd3: s = f_x & f_y;
            3'd4: s = f_x | f_y;
            3'd5: s = f_x ^ f_y;
            3'd6: s = (sx < sy) ? W'(1) : W'(0);
            default: s = (ux == uy) ? W'(1) : W'(0);
        endcase
        if (mode == 1) s = '0;
        if (mode == 2 && f_op == 3'd0) v = ~v;
        // Zero flag reflects the ALU's true result, so mode 1 only hits out_s.
        return {((mode == 1) ? '0 : s), c, (alu_ref_is_zero(f_op, f_x, f_y, f_c)), v};
    endfunction

    function automatic logic alu_ref_is_zero(input logic [2:0] f_op, input logic [W-1:0] f_x,
                                             input logic [W-1:0] f_y, input logic f_c);
        logic [W+2:0] g;
        g = alu_ref_good(f_op, f_c, f_x, f_y);
        return (g[W+2:3] == '0);
    endfunction

    function automatic logic [W+2:0] alu_ref_good(input logic [2:0] f_op, input logic f_c,
                                                  input logic [W-1:0] f_x, input logic [W-1:0] f_y);
        int ux, uy, sx, sy, r;
        logic [W-1:0] s;
        ux = int'(f_x);
        uy = int'(f_y);
        sx = $signed(f_x);
        sy = $signed(f_y);
        s = '0;
        case (f_op)
            3'd0: begin r = ux + uy + int'(f_c); s = r[W-1:0]; end
            3'd1: begin r = ux - uy; s = r[W-1:0]; end
            3'd2: s = ~f_x;
            3'd3: s = f_x & f_y;
            3'd4: s = f_x | f_y;
            3'd5: s = f_x ^ f_y;
            3'd6: s = (sx < sy) ? W'(1) : W'(0);
            default: s = (ux == uy) ? W'(1) : W'(0);
        endcase
        return {s, 3'b000};
    endfunction

    always_comb begin
        {out_s, out_c, zero, overflow} = alu_ref(op, in_c, in_x, in_y, fault_mode);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_op"},    32'(op),        32'd0);
        check_eq({tag, "_in_c"},  32'(in_c),      32'd0);
        check_eq({tag, "_in_x"},  32'(in_x),      32'd0);
        check_eq({tag, "_in_y"},  32'(in_y),      32'd0);
        check_eq({tag, "_busy"},  32'(busy),      32'd0);
        check_eq({tag, "_done"},  32'(done),      32'd0);
        check_eq({tag, "_pass"},  32'(pass),      32'd0);
        check_eq({tag, "_errs"},  32'(err_count), 32'd0);
        check_eq({tag, "_first"}, 32'(first_err), 32'd0);
    endtask

    // Expected sweep outcome: compare the (possibly faulty) ALU against the
    // fault-free one over every vector in sweep order.
    function automatic exp_t predict(input int mode);
        exp_t e;
        logic [NV-1:0] vv;
        e.errs  = 0;
        e.first = 0;
        for (int v = 0; v < NVEC; v++) begin
            vv = v[NV-1:0];
            if (alu_ref(vv[NV-1 -: 3], vv[2*W], vv[W +: W], vv[0 +: W], mode) !==
                alu_ref(vv[NV-1 -: 3], vv[2*W], vv[W +: W], vv[0 +: W], 0)) begin
                if (e.errs == 0) e.first = v;
                e.errs++;
            end
        end
        e.pass = (e.errs == 0);
        e.lat  = SWEEP_LAT;
        return e;
    endfunction

    // Start a sweep and wait for done. Cycle 1 is the edge that samples start.
    task automatic run_sweep(input string tag, input int mode, input bit mid_start);
        exp_t e;
        int   cyc;
        bit   seen;
        @(negedge clk);
        fault_mode = mode;
        sb.push_back(predict(mode));
        start = 1'b1;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < SWEEP_LAT + 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) begin
                start = 1'b0;
                check_eq({tag, "_c1_done"}, 32'(done), 32'd0);
                check_eq({tag, "_c1_errs"}, 32'(err_count), 32'd0);
                check_eq({tag, "_c1_busy"}, 32'(busy), 32'd1);
                check_eq({tag, "_c1_vec"},  32'({op, in_c, in_x, in_y}), 32'd0);
            end
            if (cyc == 4)
                check_eq({tag, "_c4_vec"}, 32'({op, in_c, in_x, in_y}), 32'd1);
            if (cyc == 2 * NVEC)
                check_eq({tag, "_last_vec"}, 32'({op, in_c, in_x, in_y}), 32'(NVEC - 1));
            if (mid_start && cyc == 100) start = 1'b1;
            if (mid_start && cyc == 101) begin
                start = 1'b0;
                check_eq({tag, "_mid_vec"}, 32'({op, in_c, in_x, in_y}), 32'(50));
            end
            seen = done;
        end
        e = sb.pop_front();
        check_eq({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        check_eq({tag, "_pass"},    32'(pass), 32'(e.pass));
        check_eq({tag, "_errs"},    32'(err_count), 32'(e.errs));
        check_eq({tag, "_first"},   32'(first_err), 32'(e.first));
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        fault_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_done", 32'(done), 32'd0);

        // Good ALU, with a start pulse mid-sweep that must be ignored.
        run_sweep("clean", 0, 1'b1);

        // out_s stuck at 0: first failure is add x=0 y=1.
        run_sweep("stuck", 1, 1'b0);
        check_eq("stuck_pass_spec",  32'(pass),      32'd0);
        check_eq("stuck_first_spec", 32'(first_err), 32'h001);

        // Restart from FIN after a failing sweep; add overflow inverted.
        run_sweep("ovinv", 2, 1'b0);
        check_eq("ovinv_errs_spec",  32'(err_count), 32'd512);
        check_eq("ovinv_first_spec", 32'(first_err), 32'h000);

        // Abort a faulty sweep with reset at cycle 3000.
        @(negedge clk);
        fault_mode = 2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2999) @(posedge clk);
        @(negedge clk);
        check_eq("abort_busy_pre", 32'(busy), 32'd1);
        check_eq("abort_errs_pre", 32'(err_count), 32'd512);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        fault_mode = 0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        run_sweep("after_rst", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
